// File: rtl/counter_display.sv
// ============================================================================
// Module  : counter_display
// Brief   : Two-digit decimal up/down counter driving two active-low 7-seg
//           displays. Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_display #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_COUNT   = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       increment,
    input  logic       decrease,
    output logic [6:0] display_one_out,
    output logic [6:0] display_two_out
);

    localparam logic [6:0] c_max_count = 7'(MAX_COUNT);
    localparam logic [6:0] c_seg_blank = 7'h7F;

    logic [1:0] w_btn;
    logic [1:0] w_pulse;
    logic [6:0] r_count;
    logic [3:0] w_tens;
    logic [3:0] w_units;

    assign w_btn = {decrease, increment};

    // Bit 0 = increment path, bit 1 = decrease path
    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_hist;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync <= '0;
                r_hist <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_btn[i]};
                r_hist <= r_sync[SYNC_STAGES-1];
            end
        end

        assign w_pulse[i] = r_sync[SYNC_STAGES-1] & ~r_hist;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case (w_pulse)
                2'b01:   r_count <= (r_count == c_max_count) ? 7'd0 : r_count + 7'd1;
                2'b10:   r_count <= (r_count == 7'd0) ? c_max_count : r_count - 7'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tens digit by threshold compare; units is the remainder
    always_comb begin
        w_tens = 4'd0;
        for (int t = 1; t <= 9; t++) begin
            if (r_count >= 7'(10 * t)) begin
                w_tens = 4'(t);
            end
        end
        w_units = 4'(r_count - 7'(w_tens) * 7'd10);
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = c_seg_blank;
        endcase
    endfunction

    assign display_one_out = seg7(w_units);

`ifdef LEADING_ZERO_BLANK_EN
    assign display_two_out = (w_tens == 4'd0) ? c_seg_blank : seg7(w_tens);
`else
    assign display_two_out = seg7(w_tens);
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter_display.sv
// ============================================================================
// Module  : tb_counter_display
// Brief   : Scoreboard bench for counter_display (button presses vs. model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_display;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_COUNT   = 99;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       increment = 1'b0;
    logic       decrease = 1'b0;
    logic [6:0] display_one_out;
    logic [6:0] display_two_out;

    counter_display #(
        .SYNC_STAGES (SYNC_STAGES),
        .MAX_COUNT   (MAX_COUNT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .increment       (increment),
        .decrease        (decrease),
        .display_one_out (display_one_out),
        .display_two_out (display_two_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [13:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  model_cnt = 0;

    task automatic check(input string tag, input logic [13:0] act, input logic [13:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got two/one=%h/%h expected %h/%h",
                      tag, act[13:7], act[6:0], exp[13:7], exp[6:0]);
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [13:0] exp_disp(input int c);
        logic [6:0] two;
        two = seg(c / 10);
`ifdef LEADING_ZERO_BLANK_EN
        if (c / 10 == 0) two = 7'h7F;
`endif
        return {two, seg(c % 10)};
    endfunction

    task automatic push_exp(input string tag);
        sb_t item;
        item.tag = tag;
        item.exp = exp_disp(model_cnt);
        sb.push_back(item);
    endtask

    task automatic pop_check();
        sb_t item;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: queue empty, got %h/%h expected an entry",
                     display_two_out, display_one_out);
        end else begin
            item = sb.pop_front();
            check(item.tag, {display_two_out, display_one_out}, item.exp);
        end
    endtask

    // Advance one rising edge, return at the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        model_cnt = 0;
        push_exp("reset");
        pop_check();
    endtask

    // One-cycle press, then enough idle edges for pulse and history to settle
    task automatic press(input logic inc, input logic dec, input string tag);
        increment = inc;
        decrease  = dec;
        tick();
        increment = 1'b0;
        decrease  = 1'b0;
        repeat (SYNC_STAGES + 2) tick();
        if (inc && !dec) model_cnt = (model_cnt == MAX_COUNT) ? 0 : model_cnt + 1;
        else if (dec && !inc) model_cnt = (model_cnt == 0) ? MAX_COUNT : model_cnt - 1;
        push_exp(tag);
        pop_check();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset(2);

        // Latency and hold: count must change exactly SYNC_STAGES edges after first sample
        increment = 1'b1;
        for (int i = 0; i < SYNC_STAGES; i++) begin
            tick();
            push_exp("latency_hold_old");
            pop_check();
        end
        tick();
        model_cnt = 1;
        push_exp("latency_new");
        pop_check();
        repeat (10 - SYNC_STAGES - 1) tick();
        push_exp("held_single");
        pop_check();
        increment = 1'b0;
        repeat (SYNC_STAGES + 2) tick();
        push_exp("after_release");
        pop_check();

        // Carry to 12, then up to 99 and wrap to 00
        for (int i = 0; i < 11; i++) press(1'b1, 1'b0, "inc_to_12");
        for (int i = 0; i < 87; i++) press(1'b1, 1'b0, "inc_to_99");
        press(1'b1, 1'b0, "wrap_up");

        // Wrap down from 0
        do_reset(1);
        press(1'b0, 1'b1, "wrap_down_99");
        press(1'b0, 1'b1, "dec_98");

        // Simultaneous presses cancel
        do_reset(1);
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0, "inc_to_5");
        press(1'b1, 1'b1, "both_hold_5");
        press(1'b0, 1'b1, "dec_4");
        press(1'b1, 1'b0, "inc_5");

        // Reset on the same edge a pulse would land
        increment = 1'b1;
        tick();
        increment = 1'b0;
        repeat (SYNC_STAGES - 1) tick();
        do_reset(1);
        repeat (SYNC_STAGES + 2) tick();
        push_exp("pulse_killed_by_reset");
        pop_check();

        // Reset mid-press: held button acts as a fresh press afterwards
        increment = 1'b1;
        repeat (3) tick();
        do_reset(1);
        repeat (SYNC_STAGES + 3) tick();
        model_cnt = 1;
        push_exp("fresh_press_after_reset");
        pop_check();
        increment = 1'b0;
        repeat (SYNC_STAGES + 2) tick();

        // 7 and 10 exercise the optional tens blanking boundary
        for (int i = 0; i < 6; i++) press(1'b1, 1'b0, "inc_to_7");
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, "inc_to_10");

        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
